wb_aperture_ctrl: RTL

Registered Wishbone aperture controller placed between the AHB-to-FPGA bridge and the FPGA IP submodules. It decodes the upper address bits into one-hot submodule chip-selects and sequences each access through a small state machine. It returns the selected submodule's read data with a single-cycle ACK. Unmapped accesses and submodules that fail to ACK within a timeout receive a default-value ACK, and a sticky error status is logged for them.

---
 rtl/wb_aperture_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/wb_aperture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wb_aperture_ctrl
// Brief    : Wishbone aperture decoder and access sequencer with slave
//            timeout, default-value ACK and sticky error log.
// Revision : 1.0 - initial release
// ============================================================================

module wb_aperture_ctrl #(
    parameter int          APERWIDTH          = 17,
    parameter int          APERSIZE           = 10,
    parameter int          NUM_SLAVES         = 4,
    parameter logic [(APERWIDTH-APERSIZE)*NUM_SLAVES-1:0] SLV_BASE = {7'h14, 7'h10, 7'h0C, 7'h04},
    parameter int          TIMEOUT_CYCLES     = 15,
    parameter int          CNT_WIDTH          = 4,
    parameter logic [31:0] DEFAULT_READ_VALUE = 32'hBADFABAC
) (
    input  logic                     WB_CLK,
    input  logic                     WB_RST_n,
    input  logic [APERWIDTH-1:0]     WBs_ADR_i,
    input  logic                     WBs_CYC_i,
    input  logic                     WBs_STB_i,
    output logic [31:0]              WBs_RD_DAT_o,
    output logic                     WBs_ACK_o,
    output logic [NUM_SLAVES-1:0]    slv_CYC_o,
    input  logic [NUM_SLAVES-1:0]    slv_ACK_i,
    input  logic [32*NUM_SLAVES-1:0] slv_DAT_i,
    output logic                     err_o,
    output logic [APERWIDTH-1:0]     err_addr_o,
    output logic [7:0]               err_cnt_o,
    input  logic                     err_clr_i
);

    localparam int                   c_TAG_W    = APERWIDTH - APERSIZE;
    localparam int                   c_IDX_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_IDX_W-1:0]    r_idx;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [APERWIDTH-1:0]  r_adr;

    logic [NUM_SLAVES-1:0] w_hit;
    logic                  w_any_hit;
    logic [c_IDX_W-1:0]    w_hit_idx;
    logic [NUM_SLAVES-1:0] w_hit_onehot;
    logic                  w_req;
    logic                  w_sel_ack;
    logic [31:0]           w_sel_dat;
    logic                  w_timeout;
    logic                  w_start;
    logic                  w_miss;
    logic                  w_abort;
    logic                  w_take_ack;
    logic                  w_take_to;
    logic                  w_err_evt;
    logic [APERWIDTH-1:0]  w_err_adr;

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_hit
            assign w_hit[gi] = (WBs_ADR_i[APERWIDTH-1:APERSIZE] == SLV_BASE[gi*c_TAG_W +: c_TAG_W]);
        end
    endgenerate

    assign w_any_hit = |w_hit;

    // Scan from the top so the lowest matching slot is the one that sticks.
    always_comb begin
        w_hit_idx    = '0;
        w_hit_onehot = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_hit_idx       = c_IDX_W'(i);
                w_hit_onehot    = '0;
                w_hit_onehot[i] = 1'b1;
            end
        end
    end

    // A request is not re-accepted while its ACK is still on the bus.
    assign w_req     = WBs_CYC_i && WBs_STB_i && !WBs_ACK_o;
    assign w_sel_ack = slv_ACK_i[r_idx];
    assign w_sel_dat = slv_DAT_i[32*r_idx +: 32];
    assign w_timeout = (r_cnt == c_CNT_LAST);

    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_req) w_state_nxt = w_any_hit ? c_BUSY : c_DONE;
            c_BUSY: begin
                if (!WBs_CYC_i)                   w_state_nxt = c_IDLE;
                else if (w_sel_ack || w_timeout)  w_state_nxt = c_DONE;
            end
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_start    = (r_state == c_IDLE) && w_req;
        w_miss     = w_start && !w_any_hit;
        w_abort    = (r_state == c_BUSY) && !WBs_CYC_i;
        w_take_ack = (r_state == c_BUSY) && WBs_CYC_i && w_sel_ack;
        w_take_to  = (r_state == c_BUSY) && WBs_CYC_i && !w_sel_ack && w_timeout;
        w_err_evt  = w_miss || w_take_to;
        w_err_adr  = w_miss ? WBs_ADR_i : r_adr;
    end

    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            WBs_ACK_o    <= 1'b0;
            WBs_RD_DAT_o <= '0;
            slv_CYC_o    <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_adr        <= '0;
        end else begin
            WBs_ACK_o <= (r_state == c_DONE);
            if (w_start) begin
                r_adr <= WBs_ADR_i;
                r_cnt <= '0;
                if (w_any_hit) begin
                    r_idx     <= w_hit_idx;
                    slv_CYC_o <= w_hit_onehot;
                end else begin
                    WBs_RD_DAT_o <= DEFAULT_READ_VALUE;
                end
            end else if (w_abort) begin
                slv_CYC_o <= '0;
            end else if (w_take_ack) begin
                WBs_RD_DAT_o <= w_sel_dat;
                slv_CYC_o    <= '0;
            end else if (w_take_to) begin
                WBs_RD_DAT_o <= DEFAULT_READ_VALUE;
                slv_CYC_o    <= '0;
            end else if (r_state == c_BUSY) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // A clear coinciding with a new error leaves exactly that one error logged.
    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            err_o      <= 1'b0;
            err_addr_o <= '0;
            err_cnt_o  <= '0;
        end else if (err_clr_i) begin
            err_o      <= w_err_evt;
            err_addr_o <= w_err_evt ? w_err_adr : '0;
            err_cnt_o  <= {7'd0, w_err_evt};
        end else if (w_err_evt) begin
            err_o      <= 1'b1;
            err_addr_o <= w_err_adr;
            err_cnt_o  <= (err_cnt_o == 8'hFF) ? 8'hFF : err_cnt_o + 8'd1;
        end
    end

endmodule

`default_nettype wire
